// File: rtl/sd_bd_queue_pkg.sv
// ============================================================================
//  sd_bd_queue_pkg
//  Shared constants for the buffer-descriptor queue: beat/descriptor geometry.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sd_bd_queue_pkg;

    localparam int SD_RAM_MEM_WIDTH = 16;   // default beat width from register slave
    localparam int SD_BD_SIZE       = 8;    // default descriptor slots
    localparam int BD_W             = 64;   // descriptor width
    localparam int BD_WORD_W        = 32;   // width of each descriptor word
    localparam int BD_WORD_SYS      = 0;    // word0: system memory address
    localparam int BD_WORD_BLK      = 1;    // word1: card block address

    function automatic int bd_beats(input int beat_width);
        return BD_W / beat_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd_bd_ram.sv
// ============================================================================
//  sd_bd_ram
//  Descriptor storage: DEPTH x WIDTH register array, one write port and one
//  asynchronous read port. Contents are intentionally not reset.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sd_bd_ram #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sd_bd_queue.sv
// ============================================================================
//  sd_bd_queue
//  Packs register-slave beats into 64-bit buffer descriptors and queues them
//  in a circular FIFO for the DMA master; reports free slots back to the slave.
//  Optional feature macro: SD_BD_OVF_DETECT_EN (sticky overflow flag).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sd_bd_queue
    import sd_bd_queue_pkg::*;
#(
    parameter int RAM_MEM_WIDTH = SD_RAM_MEM_WIDTH,
    parameter int BD_DEPTH      = SD_BD_SIZE,
    parameter int PTR_W         = $clog2(BD_DEPTH)
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     soft_rst_i,
    input  logic                     we_m_bd,
    input  logic [RAM_MEM_WIDTH-1:0] dat_in_m_bd,
    output logic                     bd_valid_o,
    output logic [BD_WORD_W-1:0]     bd_sys_adr_o,
    output logic [BD_WORD_W-1:0]     bd_blk_adr_o,
    input  logic                     bd_pop_i,
    output logic [7:0]               bd_free_o,
    output logic                     bd_empty_o,
    output logic                     bd_ovf_o
);

    localparam int                BEATS     = bd_beats(RAM_MEM_WIDTH);
    localparam int                BEAT_W    = $clog2(BEATS);
    localparam int                STAGE_W   = BD_W - RAM_MEM_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(BD_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [BEAT_W-1:0] beat_cnt;
    logic [STAGE_W-1:0] staging;
    logic [BD_W-1:0]   desc;
    logic [BD_W-1:0]   head;
    logic              pop_ok;
    logic              commit;
    logic              full;
    logic              store;
    logic              drop;

    assign full   = (count == FULL_CNT);
    assign pop_ok = bd_pop_i & (count != '0);
    assign commit = we_m_bd & (beat_cnt == LAST_BEAT);
    // A pop in the same cycle frees the head slot before the write lands.
    assign store  = commit & (~full | pop_ok);
    assign drop   = commit & full & ~pop_ok;
    assign desc   = {dat_in_m_bd, staging};

    // Beat assembly: earlier beats are parked LSB-first, the last beat goes straight to RAM.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            beat_cnt <= '0;
            staging  <= '0;
        end else if (soft_rst_i) begin
            beat_cnt <= '0;
            staging  <= '0;
        end else if (we_m_bd) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
            for (int b = 0; b < BEATS - 1; b++) begin
                if (beat_cnt == BEAT_W'(b)) begin
                    staging[b*RAM_MEM_WIDTH +: RAM_MEM_WIDTH] <= dat_in_m_bd;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (soft_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({store, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SD_BD_OVF_DETECT_EN
    logic ovf;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ovf <= 1'b0;
        end else if (soft_rst_i) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    assign bd_ovf_o = ovf;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign bd_ovf_o    = 1'b0;
`endif

    sd_bd_ram #(
        .DEPTH (BD_DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (BD_W)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (desc),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head data is forced to zero while empty so stale RAM contents never leak out.
    assign bd_valid_o   = (count != '0);
    assign bd_empty_o   = (count == '0);
    assign bd_free_o    = 8'(BD_DEPTH) - 8'(count);
    assign bd_sys_adr_o = bd_valid_o ? head[BD_WORD_SYS*BD_WORD_W +: BD_WORD_W] : '0;
    assign bd_blk_adr_o = bd_valid_o ? head[BD_WORD_BLK*BD_WORD_W +: BD_WORD_W] : '0;

endmodule

`default_nettype wire
